// File: rtl/acq_pkg.sv
// Shared types and default constants for the acquisition controller.
package acq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_NEXT_BIN,
    ST_DECIDE,
    ST_REPORT,
    ST_ALIGN
  } state_t;

  localparam int          CODE_LEN_DEF   = 8184;
  localparam logic [31:0] FCW_BASE_DEF   = 32'd1342177280;
  localparam logic [31:0] FCW_STEP_DEF   = 32'd2684;
  localparam int          CORR_WIDTH_DEF = 32;
  localparam int          PHS_WIDTH_DEF  = 14;
  localparam int          BIN_WIDTH_DEF  = 5;

  // Field widths follow the default correlator/phase/bin widths of the top.
  typedef struct packed {
    logic [CORR_WIDTH_DEF-1:0] peak;
    logic [PHS_WIDTH_DEF-1:0]  phs;
    logic [BIN_WIDTH_DEF-1:0]  bin;
  } result_t;

endpackage

// File: rtl/acq_max_sel.sv
// Combinational N-way argmax over strobed channels; lowest index wins ties.
module acq_max_sel #(
  parameter int N_CH  = 4,
  parameter int W     = 32,
  parameter int IDX_W = 2
) (
  input  logic [N_CH*W-1:0] val_i,
  input  logic [N_CH-1:0]   stb_i,
  output logic [W-1:0]      max_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              vld_o,
  output logic [N_CH-1:0]   lose_o
);

  always_comb begin
    max_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    // Strict compare keeps the earlier (lower) index on equal values.
    for (int i = 0; i < N_CH; i++) begin
      if (stb_i[i] && (!vld_o || (val_i[i*W +: W] > max_o))) begin
        max_o = val_i[i*W +: W];
        idx_o = IDX_W'(i);
        vld_o = 1'b1;
      end
    end
    lose_o = stb_i;
    for (int i = 0; i < N_CH; i++) begin
      if (vld_o && (idx_o == IDX_W'(i))) lose_o[i] = 1'b0;
    end
  end

endmodule

// File: rtl/acq_peak_ctrl.sv
// Doppler/code-phase acquisition controller with absolute threshold; the
// second-peak ratio test is built only when ACQ_PEAK_RATIO_EN is defined.
module acq_peak_ctrl
  import acq_pkg::*;
#(
  parameter int                   N_CH        = 4,
  parameter int                   CORR_WIDTH  = 32,
  parameter int                   PHS_WIDTH   = 14,
  parameter int                   CODE_LEN    = CODE_LEN_DEF,
  parameter int                   BIN_WIDTH   = 5,
  parameter int                   NUM_BIN     = 16,
  parameter int                   FCW_WIDTH   = 32,
  parameter logic [FCW_WIDTH-1:0] FCW_BASE    = FCW_BASE_DEF,
  parameter logic [FCW_WIDTH-1:0] FCW_STEP    = FCW_STEP_DEF,
  parameter int                   RATIO_SHIFT = 1
) (
  input  logic                       rx_clk,
  input  logic                       rx_rst,
  input  logic                       rx_start,
  input  logic [CORR_WIDTH-1:0]      rx_thresh,
  input  logic [N_CH*CORR_WIDTH-1:0] rx_corr_acc,
  input  logic [N_CH-1:0]            rx_corr_eop,
  input  logic [PHS_WIDTH-1:0]       rx_loc_phs,
  input  logic                       rx_acq_ready,
  output logic [FCW_WIDTH-1:0]       tx_car_fcw,
  output logic                       tx_corr_rst,
  output logic                       tx_busy,
  output logic                       tx_acq_valid,
  output logic                       tx_acq_fail,
  output logic [PHS_WIDTH-1:0]       tx_acq_phs,
  output logic [BIN_WIDTH-1:0]       tx_acq_bin,
  output logic [CORR_WIDTH-1:0]      tx_acq_peak,
  output logic                       tx_trk_align,
  output state_t                     dbg_state
);

  localparam int                   IDX_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int                   RW       = CORR_WIDTH + RATIO_SHIFT;
  localparam logic [PHS_WIDTH-1:0] LAST_PHS = PHS_WIDTH'(CODE_LEN - 1);
  localparam logic [PHS_WIDTH-1:0] PHS_STEP = PHS_WIDTH'(N_CH);
  localparam logic [BIN_WIDTH-1:0] LAST_BIN = BIN_WIDTH'(NUM_BIN - 1);

  state_t                 state_q;
  logic [BIN_WIDTH-1:0]   bin_q;
  logic [CORR_WIDTH-1:0]  thresh_q;
  logic [PHS_WIDTH-1:0]   phs_q [N_CH];
  result_t                best_q, best_d;
  logic [FCW_WIDTH-1:0]   car_fcw_q;
  logic                   corr_rst_q, acq_valid_q, acq_fail_q, trk_align_q;
  logic [PHS_WIDTH-1:0]   acq_phs_q;
  logic [BIN_WIDTH-1:0]   acq_bin_q;
  logic [CORR_WIDTH-1:0]  acq_peak_q;

  logic                   sweep, bin_end, ratio_ok, pass;
  logic [N_CH-1:0]        stb, lose_mask;
  logic [CORR_WIDTH-1:0]  max_val;
  logic [IDX_W-1:0]       max_idx;
  logic                   max_vld;

  assign sweep   = (state_q == ST_SWEEP);
  assign stb     = sweep ? rx_corr_eop : '0;
  assign bin_end = stb[N_CH-1] && (phs_q[N_CH-1] == LAST_PHS);

  acq_max_sel #(.N_CH(N_CH), .W(CORR_WIDTH), .IDX_W(IDX_W)) u_max_sel (
    .val_i  (rx_corr_acc),
    .stb_i  (stb),
    .max_o  (max_val),
    .idx_o  (max_idx),
    .vld_o  (max_vld),
    .lose_o (lose_mask)
  );

  always_comb begin
    best_d = best_q;
    if (max_vld && (max_val > best_q.peak)) begin
      best_d.peak = max_val;
      best_d.phs  = phs_q[max_idx];
      best_d.bin  = bin_q;
    end
  end

`ifdef ACQ_PEAK_RATIO_EN
  logic [CORR_WIDTH-1:0] second_q, second_d;

  // A displaced best and every losing strobe are both candidates for second.
  always_comb begin
    second_d = second_q;
    if (max_vld) begin
      if (max_val > best_q.peak) begin
        if (best_q.peak > second_d) second_d = best_q.peak;
      end else if (max_val > second_d) begin
        second_d = max_val;
      end
      for (int i = 0; i < N_CH; i++) begin
        if (lose_mask[i] && (rx_corr_acc[i*CORR_WIDTH +: CORR_WIDTH] > second_d))
          second_d = rx_corr_acc[i*CORR_WIDTH +: CORR_WIDTH];
      end
    end
  end

  always_ff @(posedge rx_clk or negedge rx_rst) begin
    if (!rx_rst)                           second_q <= '0;
    else if ((state_q == ST_IDLE) && rx_start) second_q <= '0;
    else if (sweep)                        second_q <= second_d;
  end

  assign ratio_ok = RW'(best_q.peak) >= (RW'(second_q) << RATIO_SHIFT);
`else
  logic unused_lose;
  assign unused_lose = ^lose_mask;
  assign ratio_ok    = 1'b1;
`endif

  assign pass = (best_q.peak >= thresh_q) && ratio_ok;

  always_ff @(posedge rx_clk or negedge rx_rst) begin
    if (!rx_rst) begin
      state_q     <= ST_IDLE;
      bin_q       <= '0;
      thresh_q    <= '0;
      best_q      <= '0;
      car_fcw_q   <= FCW_BASE;
      corr_rst_q  <= 1'b0;
      acq_valid_q <= 1'b0;
      acq_fail_q  <= 1'b0;
      acq_phs_q   <= '0;
      acq_bin_q   <= '0;
      acq_peak_q  <= '0;
      trk_align_q <= 1'b0;
      for (int i = 0; i < N_CH; i++) phs_q[i] <= '0;
    end else begin
      corr_rst_q  <= 1'b0;
      trk_align_q <= 1'b0;
      if (sweep) begin
        best_q <= best_d;
        for (int i = 0; i < N_CH; i++) begin
          if (stb[i]) phs_q[i] <= phs_q[i] + PHS_STEP;
        end
      end
      case (state_q)
        ST_IDLE: begin
          if (rx_start) begin
            state_q    <= ST_SWEEP;
            thresh_q   <= rx_thresh;
            bin_q      <= '0;
            car_fcw_q  <= FCW_BASE;
            best_q     <= '0;
            corr_rst_q <= 1'b1;
            for (int i = 0; i < N_CH; i++) phs_q[i] <= PHS_WIDTH'(i);
          end
        end
        ST_SWEEP: begin
          if (bin_end) state_q <= (bin_q == LAST_BIN) ? ST_DECIDE : ST_NEXT_BIN;
        end
        ST_NEXT_BIN: begin
          state_q    <= ST_SWEEP;
          bin_q      <= bin_q + BIN_WIDTH'(1);
          car_fcw_q  <= car_fcw_q + FCW_STEP;
          corr_rst_q <= 1'b1;
          for (int i = 0; i < N_CH; i++) phs_q[i] <= PHS_WIDTH'(i);
        end
        ST_DECIDE: begin
          state_q     <= ST_REPORT;
          acq_valid_q <= 1'b1;
          acq_fail_q  <= !pass;
          acq_phs_q   <= best_q.phs;
          acq_bin_q   <= best_q.bin;
          acq_peak_q  <= best_q.peak;
        end
        // Handshake: valid and the result fields hold until a cycle with
        // valid && ready; valid drops on the following cycle. Ready may lead valid.
        ST_REPORT: begin
          if (rx_acq_ready) begin
            acq_valid_q <= 1'b0;
            state_q     <= acq_fail_q ? ST_IDLE : ST_ALIGN;
          end
        end
        ST_ALIGN: begin
          if (rx_loc_phs == acq_phs_q) begin
            trk_align_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx_car_fcw   = car_fcw_q;
  assign tx_corr_rst  = corr_rst_q;
  assign tx_busy      = (state_q != ST_IDLE);
  assign tx_acq_valid = acq_valid_q;
  assign tx_acq_fail  = acq_fail_q;
  assign tx_acq_phs   = acq_phs_q;
  assign tx_acq_bin   = acq_bin_q;
  assign tx_acq_peak  = acq_peak_q;
  assign tx_trk_align = trk_align_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_acq_peak_ctrl.sv
// Directed bench for acq_peak_ctrl: N_CH=4, CODE_LEN=16, NUM_BIN=2.
module tb_acq_peak_ctrl;
  import acq_pkg::*;

  localparam int          N_CH     = 4;
  localparam int          CW       = 32;
  localparam int          PW       = 14;
  localparam int          BW       = 5;
  localparam int          CODE_LEN = 16;
  localparam int          NUM_BIN  = 2;
  localparam logic [31:0] BASE     = 32'd1342177280;
  localparam logic [31:0] STEP     = 32'd2684;
  localparam logic [31:0] FCW1     = BASE + STEP;
`ifdef ACQ_PEAK_RATIO_EN
  localparam bit RATIO = 1'b1;
`else
  localparam bit RATIO = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               rx_start = 1'b0;
  logic [CW-1:0]      rx_thresh = '0;
  logic [N_CH*CW-1:0] rx_corr_acc = '0;
  logic [N_CH-1:0]    rx_corr_eop = '0;
  logic [PW-1:0]      rx_loc_phs = '0;
  logic               rx_acq_ready = 1'b0;
  logic [31:0]        tx_car_fcw;
  logic               tx_corr_rst, tx_busy, tx_acq_valid, tx_acq_fail, tx_trk_align;
  logic [PW-1:0]      tx_acq_phs;
  logic [BW-1:0]      tx_acq_bin;
  logic [CW-1:0]      tx_acq_peak;
  state_t             dbg_state;

  acq_peak_ctrl #(
    .N_CH(N_CH), .CORR_WIDTH(CW), .PHS_WIDTH(PW), .CODE_LEN(CODE_LEN),
    .BIN_WIDTH(BW), .NUM_BIN(NUM_BIN), .FCW_WIDTH(32),
    .FCW_BASE(BASE), .FCW_STEP(STEP), .RATIO_SHIFT(1)
  ) dut (
    .rx_clk(clk), .rx_rst(rst_n), .rx_start(rx_start), .rx_thresh(rx_thresh),
    .rx_corr_acc(rx_corr_acc), .rx_corr_eop(rx_corr_eop), .rx_loc_phs(rx_loc_phs),
    .rx_acq_ready(rx_acq_ready), .tx_car_fcw(tx_car_fcw), .tx_corr_rst(tx_corr_rst),
    .tx_busy(tx_busy), .tx_acq_valid(tx_acq_valid), .tx_acq_fail(tx_acq_fail),
    .tx_acq_phs(tx_acq_phs), .tx_acq_bin(tx_acq_bin), .tx_acq_peak(tx_acq_peak),
    .tx_trk_align(tx_trk_align), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: {fail, phs, bin, peak}
  logic [51:0] exp_q[$];
  logic [31:0] tbl [NUM_BIN][CODE_LEN];

  task automatic fill(input logic [31:0] v);
    for (int b = 0; b < NUM_BIN; b++)
      for (int p = 0; p < CODE_LEN; p++) tbl[b][p] = v;
  endtask

  // channel ch reports phase 4k+ch on dwell cycle k
  task automatic drive_cycles(input int b, input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      rx_corr_eop = '1;
      for (int ch = 0; ch < N_CH; ch++) rx_corr_acc[ch*CW +: CW] = tbl[b][4*k+ch];
      @(posedge clk); #1;
    end
    rx_corr_eop = '0;
  endtask

  task automatic check_result(input string tag);
    logic [51:0] e;
    chk({tag, "_exp_q"}, 64'(exp_q.size()), 64'd1);
    e = exp_q.pop_front();
    chk({tag, "_fail"}, 64'(tx_acq_fail), 64'(e[51]));
    chk({tag, "_phs"},  64'(tx_acq_phs),  64'(e[50:37]));
    chk({tag, "_bin"},  64'(tx_acq_bin),  64'(e[36:32]));
    chk({tag, "_peak"}, 64'(tx_acq_peak), 64'(e[31:0]));
  endtask

  task automatic run_search(input string tag, input logic [31:0] thr);
    rx_thresh = thr;
    rx_start  = 1'b1;
    @(posedge clk); #1;
    rx_start  = 1'b0;
    chk({tag, "_start_corr_rst"}, 64'(tx_corr_rst), 64'd1);
    chk({tag, "_start_busy"},     64'(tx_busy),     64'd1);
    chk({tag, "_fcw_bin0"},       64'(tx_car_fcw),  64'(BASE));
    drive_cycles(0, 4);
    chk({tag, "_bin_end"},        64'(dbg_state),   64'(ST_NEXT_BIN));
    @(posedge clk); #1;
    chk({tag, "_bin1_corr_rst"},  64'(tx_corr_rst), 64'd1);
    chk({tag, "_fcw_bin1"},       64'(tx_car_fcw),  64'(FCW1));
    drive_cycles(1, 4);
    chk({tag, "_decide"},         64'(dbg_state),   64'(ST_DECIDE));
    chk({tag, "_valid_pre"},      64'(tx_acq_valid), 64'd0);
    @(posedge clk); #1;
    chk({tag, "_valid"},          64'(tx_acq_valid), 64'd1);
    check_result(tag);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (dbg_state != ST_IDLE && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_idle"}, 64'(dbg_state), 64'(ST_IDLE));
    chk({tag, "_busy_low"}, 64'(tx_busy), 64'd0);
  endtask

  // ready already high: handshake on the first valid cycle
  task automatic quick_search(input string tag, input logic [31:0] thr, input logic [PW-1:0] phs);
    rx_acq_ready = 1'b1;
    rx_loc_phs   = phs;
    run_search(tag, thr);
    @(posedge clk); #1;
    chk({tag, "_valid_drop"}, 64'(tx_acq_valid), 64'd0);
    wait_idle(tag);
    rx_acq_ready = 1'b0;
  endtask

  initial begin
    int pulses;
    int at_phs;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 64'(dbg_state),   64'(ST_IDLE));
    chk("rst_fcw",   64'(tx_car_fcw),  64'(BASE));
    chk("rst_busy",  64'(tx_busy),     64'd0);
    chk("rst_valid", 64'(tx_acq_valid), 64'd0);
    chk("rst_peak",  64'(tx_acq_peak), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // T1: single peak in bin 1, ready held off, then alignment sweep
    fill(32'd10);
    tbl[1][9] = 32'd500;
    exp_q.push_back({1'b0, 14'd9, 5'd1, 32'd500});
    rx_acq_ready = 1'b0;
    rx_loc_phs   = '0;
    run_search("t1", 32'd100);
    chk("t1_fcw_final", 64'(tx_car_fcw), 64'(FCW1));
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      chk("t1_hold_valid", 64'(tx_acq_valid), 64'd1);
      chk("t1_hold_phs",   64'(tx_acq_phs),   64'd9);
      chk("t1_hold_peak",  64'(tx_acq_peak),  64'd500);
    end
    rx_acq_ready = 1'b1;
    @(posedge clk); #1;
    rx_acq_ready = 1'b0;
    chk("t1_valid_drop", 64'(tx_acq_valid), 64'd0);
    chk("t1_align_state", 64'(dbg_state), 64'(ST_ALIGN));
    pulses = 0;
    at_phs = -1;
    for (int v = 0; v < 16; v++) begin
      rx_loc_phs = PW'(v);
      @(posedge clk); #1;
      if (tx_trk_align) begin
        pulses++;
        at_phs = v;
      end
    end
    chk("t1_align_pulses", 64'(pulses), 64'd1);
    chk("t1_align_phs",    64'(at_phs), 64'd9);
    chk("t1_align_idle",   64'(dbg_state), 64'(ST_IDLE));

    // T2: second peak 300 in bin 0 defeats the 2x ratio when enabled
    fill(32'd10);
    tbl[0][3] = 32'd300;
    tbl[1][9] = 32'd500;
    exp_q.push_back({RATIO, 14'd9, 5'd1, 32'd500});
    quick_search("t2", 32'd100, 14'd9);

    // T3: equal values on all channels at once, phases 4..7
    fill(32'd10);
    for (int p = 4; p < 8; p++) tbl[0][p] = 32'd200;
    exp_q.push_back({RATIO, 14'd4, 5'd0, 32'd200});
    quick_search("t3", 32'd100, 14'd4);

    // T4: best just under threshold
    fill(32'd10);
    tbl[1][2] = 32'd99;
    exp_q.push_back({1'b1, 14'd2, 5'd1, 32'd99});
    quick_search("t4", 32'd100, 14'd2);

    // T5: reset mid-sweep in bin 1, with a start pulse while busy
    fill(32'd999);
    rx_thresh = 32'd100;
    rx_start  = 1'b1;
    @(posedge clk); #1;
    rx_start  = 1'b0;
    drive_cycles(0, 4);
    @(posedge clk); #1;
    chk("t5_fcw_bin1", 64'(tx_car_fcw), 64'(FCW1));
    drive_cycles(1, 2);
    rx_start = 1'b1;
    @(posedge clk); #1;
    rx_start = 1'b0;
    chk("t5_busy_start_ign", 64'(tx_corr_rst), 64'd0);
    chk("t5_busy_state",     64'(dbg_state),   64'(ST_SWEEP));
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_state", 64'(dbg_state),   64'(ST_IDLE));
    chk("t5_rst_fcw",   64'(tx_car_fcw),  64'(BASE));
    chk("t5_rst_busy",  64'(tx_busy),     64'd0);
    chk("t5_rst_crst",  64'(tx_corr_rst), 64'd0);
    chk("t5_rst_valid", 64'(tx_acq_valid), 64'd0);
    chk("t5_rst_phs",   64'(tx_acq_phs),  64'd0);
    chk("t5_rst_peak",  64'(tx_acq_peak), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // T6: peak equal to threshold on the bin-end phase 15
    fill(32'd10);
    tbl[0][15] = 32'd100;
    exp_q.push_back({1'b0, 14'd15, 5'd0, 32'd100});
    quick_search("t6", 32'd100, 14'd15);

    // T7: equal peaks in two bins; earlier bin kept, becomes second under ratio
    fill(32'd10);
    tbl[0][6] = 32'd300;
    tbl[1][1] = 32'd300;
    exp_q.push_back({RATIO, 14'd6, 5'd0, 32'd300});
    quick_search("t7", 32'd100, 14'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
